// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared constants for the ID/EX boundary: control-word layout and ARM condition codes.
package id_ex_pipe_reg_pkg;

  localparam int CU_W      = 9;
  localparam int CU_S      = 0;
  localparam int CU_B      = 1;
  localparam int CU_EXE_LO = 2;
  localparam int CU_EXE_HI = 5;
  localparam int CU_MEM_W  = 6;
  localparam int CU_MEM_R  = 7;
  localparam int CU_WB     = 8;

  // Flag positions inside the {N,Z,C,V} status nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/id_ex_pipe_reg_cond_check.sv
// Combinational ARM condition evaluator; also shared with the status-register bypass path.
module cond_check
  import id_ex_pipe_reg_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic flagN, flagZ, flagC, flagV;

  assign flagN = nzcv_i[FLAG_N];
  assign flagZ = nzcv_i[FLAG_Z];
  assign flagC = nzcv_i[FLAG_C];
  assign flagV = nzcv_i[FLAG_V];

  // Decode the condition field against the current flags; 1111 behaves as always
  always_comb begin
    pass_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = flagZ;
      COND_NE: pass_o = ~flagZ;
      COND_CS: pass_o = flagC;
      COND_CC: pass_o = ~flagC;
      COND_MI: pass_o = flagN;
      COND_PL: pass_o = ~flagN;
      COND_VS: pass_o = flagV;
      COND_VC: pass_o = ~flagV;
      COND_HI: pass_o = flagC & ~flagZ;
      COND_LS: pass_o = ~flagC | flagZ;
      COND_GE: pass_o = (flagN == flagV);
      COND_LT: pass_o = (flagN != flagV);
      COND_GT: pass_o = ~flagZ & (flagN == flagV);
      COND_LE: pass_o = flagZ | (flagN != flagV);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b1;
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with condition squash and freeze/flush/hazard bubble policy.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze_i,
  input  logic              flush_i,
  input  logic              hazard_i,
  input  logic              id_valid_i,
  input  logic [31:0]       id_instr_i,
  input  logic [CU_W-1:0]   id_cu_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [DATA_W-1:0] id_val_rn_i,
  input  logic [DATA_W-1:0] id_val_rm_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic [3:0]        status_nzcv_i,
  output logic              ex_valid_o,
  output logic              ex_s_o,
  output logic              ex_b_o,
  output logic              ex_mem_w_o,
  output logic              ex_mem_r_o,
  output logic              ex_wb_en_o,
  output logic [3:0]        ex_exe_cmd_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic [DATA_W-1:0] ex_val_rn_o,
  output logic [DATA_W-1:0] ex_val_rm_o,
  output logic              ex_imm_o,
  output logic [11:0]       ex_shift_op_o,
  output logic [23:0]       ex_simm24_o,
  output logic [REG_AW-1:0] ex_dest_o,
  output logic              ex_carry_o,
  output logic              cond_fail_o
);

  logic              condPass;
  logic              bubble;

  logic              valid_q,   valid_d;
  logic [CU_W-1:0]   cu_q,      cu_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [DATA_W-1:0] valRn_q,   valRn_d;
  logic [DATA_W-1:0] valRm_q,   valRm_d;
  logic              imm_q,     imm_d;
  logic [11:0]       shiftOp_q, shiftOp_d;
  logic [23:0]       simm24_q,  simm24_d;
  logic [REG_AW-1:0] dest_q,    dest_d;
  logic              carry_q,   carry_d;

  cond_check u_cond_check (
    .cond_i (id_instr_i[31:28]),
    .nzcv_i (status_nzcv_i),
    .pass_o (condPass)
  );

  assign cond_fail_o = ~condPass;
  assign bubble      = flush_i | hazard_i | ~id_valid_i | ~condPass;

  // Next-state selection: freeze holds everything, otherwise datapath loads through
  // and the control word is either taken from ID or cleared to a bubble
  always_comb begin
    valid_d   = valid_q;
    cu_d      = cu_q;
    pc_d      = pc_q;
    valRn_d   = valRn_q;
    valRm_d   = valRm_q;
    imm_d     = imm_q;
    shiftOp_d = shiftOp_q;
    simm24_d  = simm24_q;
    dest_d    = dest_q;
    carry_d   = carry_q;
    if (!freeze_i) begin
      pc_d      = id_pc_i;
      valRn_d   = id_val_rn_i;
      valRm_d   = id_val_rm_i;
      imm_d     = id_instr_i[25];
      shiftOp_d = id_instr_i[11:0];
      simm24_d  = id_instr_i[23:0];
      dest_d    = id_dest_i;
      if (bubble) begin
        valid_d = 1'b0;
        cu_d    = '0;
      end else begin
        valid_d = 1'b1;
        cu_d    = id_cu_i;
        carry_d = status_nzcv_i[FLAG_C];
      end
    end
  end

  // Register bank with asynchronous clear; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      cu_q      <= '0;
      pc_q      <= '0;
      valRn_q   <= '0;
      valRm_q   <= '0;
      imm_q     <= 1'b0;
      shiftOp_q <= '0;
      simm24_q  <= '0;
      dest_q    <= '0;
      carry_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      cu_q      <= cu_d;
      pc_q      <= pc_d;
      valRn_q   <= valRn_d;
      valRm_q   <= valRm_d;
      imm_q     <= imm_d;
      shiftOp_q <= shiftOp_d;
      simm24_q  <= simm24_d;
      dest_q    <= dest_d;
      carry_q   <= carry_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_s_o        = cu_q[CU_S];
  assign ex_b_o        = cu_q[CU_B];
  assign ex_mem_w_o    = cu_q[CU_MEM_W];
  assign ex_mem_r_o    = cu_q[CU_MEM_R];
  assign ex_wb_en_o    = cu_q[CU_WB];
  assign ex_exe_cmd_o  = cu_q[CU_EXE_HI:CU_EXE_LO];
  assign ex_pc_o       = pc_q;
  assign ex_val_rn_o   = valRn_q;
  assign ex_val_rm_o   = valRm_q;
  assign ex_imm_o      = imm_q;
  assign ex_shift_op_o = shiftOp_q;
  assign ex_simm24_o   = simm24_q;
  assign ex_dest_o     = dest_q;
  assign ex_carry_o    = carry_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: vector table, condition sweep and stream sequences.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic        freeze_i, flush_i, hazard_i, id_valid_i;
  logic [31:0] id_instr_i;
  logic [8:0]  id_cu_i;
  logic [31:0] id_pc_i, id_val_rn_i, id_val_rm_i;
  logic [3:0]  id_dest_i, status_nzcv_i;
  logic        ex_valid_o, ex_s_o, ex_b_o, ex_mem_w_o, ex_mem_r_o, ex_wb_en_o;
  logic [3:0]  ex_exe_cmd_o;
  logic [31:0] ex_pc_o, ex_val_rn_o, ex_val_rm_o;
  logic        ex_imm_o;
  logic [11:0] ex_shift_op_o;
  logic [23:0] ex_simm24_o;
  logic [3:0]  ex_dest_o;
  logic        ex_carry_o, cond_fail_o;

  typedef struct packed {
    logic        freeze;
    logic        flush;
    logic        hazard;
    logic        valid;
    logic [31:0] instr;
    logic [8:0]  cu;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic [3:0]  nzcv;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic        s;
    logic        b;
    logic        memW;
    logic        memR;
    logic        wb;
    logic [3:0]  cmd;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic        carry;
  } exp_t;

  typedef struct packed {
    in_t  in;
    logic expHold;
    logic expLoad;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t lastExp;

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .freeze_i(freeze_i), .flush_i(flush_i), .hazard_i(hazard_i),
    .id_valid_i(id_valid_i), .id_instr_i(id_instr_i), .id_cu_i(id_cu_i),
    .id_pc_i(id_pc_i), .id_val_rn_i(id_val_rn_i), .id_val_rm_i(id_val_rm_i),
    .id_dest_i(id_dest_i), .status_nzcv_i(status_nzcv_i),
    .ex_valid_o(ex_valid_o), .ex_s_o(ex_s_o), .ex_b_o(ex_b_o),
    .ex_mem_w_o(ex_mem_w_o), .ex_mem_r_o(ex_mem_r_o), .ex_wb_en_o(ex_wb_en_o),
    .ex_exe_cmd_o(ex_exe_cmd_o), .ex_pc_o(ex_pc_o), .ex_val_rn_o(ex_val_rn_o),
    .ex_val_rm_o(ex_val_rm_o), .ex_imm_o(ex_imm_o), .ex_shift_op_o(ex_shift_op_o),
    .ex_simm24_o(ex_simm24_o), .ex_dest_o(ex_dest_o), .ex_carry_o(ex_carry_o),
    .cond_fail_o(cond_fail_o)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition table written directly from the ARM mnemonic definitions
  function automatic logic condPassModel(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t loadedExp(input in_t v, input logic live, input exp_t prev);
    exp_t e;
    e.valid = live;
    e.s     = live & v.cu[0];
    e.b     = live & v.cu[1];
    e.cmd   = live ? v.cu[5:2] : 4'h0;
    e.memW  = live & v.cu[6];
    e.memR  = live & v.cu[7];
    e.wb    = live & v.cu[8];
    e.pc    = v.pc;
    e.rn    = v.rn;
    e.rm    = v.rm;
    e.imm   = v.instr[25];
    e.shift = v.instr[11:0];
    e.simm  = v.instr[23:0];
    e.dest  = v.dest;
    e.carry = live ? v.nzcv[1] : prev.carry;
    return e;
  endfunction

  function automatic exp_t modelNext(input in_t v, input exp_t prev);
    if (v.freeze) return prev;
    if (v.flush || v.hazard || !v.valid || !condPassModel(v.instr[31:28], v.nzcv))
      return loadedExp(v, 1'b0, prev);
    return loadedExp(v, 1'b1, prev);
  endfunction

  function automatic in_t randomIn(input logic [3:0] cond);
    in_t r;
    r.freeze = 1'b0;
    r.flush  = 1'b0;
    r.hazard = 1'b0;
    r.valid  = 1'b1;
    r.instr  = {cond, 28'($urandom)};
    r.cu     = 9'($urandom);
    r.pc     = $urandom;
    r.rn     = $urandom;
    r.rm     = $urandom;
    r.dest   = 4'($urandom);
    r.nzcv   = 4'($urandom);
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the EX outputs
  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = expQ.pop_front();
    cmp({tag, " valid"}, 32'(ex_valid_o), 32'(e.valid));
    cmp({tag, " ctrl"}, 32'({ex_s_o, ex_b_o, ex_mem_w_o, ex_mem_r_o, ex_wb_en_o, ex_exe_cmd_o}),
        32'({e.s, e.b, e.memW, e.memR, e.wb, e.cmd}));
    if (e.valid) begin
      cmp({tag, " pc"}, ex_pc_o, e.pc);
      cmp({tag, " rn"}, ex_val_rn_o, e.rn);
      cmp({tag, " rm"}, ex_val_rm_o, e.rm);
      cmp({tag, " fields"}, 32'({ex_imm_o, ex_shift_op_o, ex_dest_o, ex_carry_o}),
          32'({e.imm, e.shift, e.dest, e.carry}));
      cmp({tag, " simm24"}, 32'(ex_simm24_o), 32'(e.simm));
    end
  endtask

  task automatic checkResetState(input string tag);
    cmp({tag, " ctrl"}, 32'({ex_valid_o, ex_s_o, ex_b_o, ex_mem_w_o, ex_mem_r_o, ex_wb_en_o, ex_exe_cmd_o}), 32'h0);
    cmp({tag, " pc"}, ex_pc_o, 32'h0);
    cmp({tag, " operands"}, ex_val_rn_o | ex_val_rm_o, 32'h0);
    cmp({tag, " fields"}, 32'({ex_imm_o, ex_shift_op_o, ex_dest_o, ex_carry_o}), 32'h0);
    cmp({tag, " simm24"}, 32'(ex_simm24_o), 32'h0);
  endtask

  // Drive one ID cycle, check cond_fail, push the expectation, then check after the edge
  task automatic applyStimulus(input in_t v, input exp_t e, input string tag);
    @(negedge clk);
    freeze_i = v.freeze; flush_i = v.flush; hazard_i = v.hazard; id_valid_i = v.valid;
    id_instr_i = v.instr; id_cu_i = v.cu; id_pc_i = v.pc; id_val_rn_i = v.rn;
    id_val_rm_i = v.rm; id_dest_i = v.dest; status_nzcv_i = v.nzcv;
    #1;
    cmp({tag, " cond_fail"}, 32'(cond_fail_o), 32'(!condPassModel(v.instr[31:28], v.nzcv)));
    expQ.push_back(e);
    lastExp = e;
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  vec_t vecs[10];

  initial begin
    in_t  v;
    exp_t e;
    int   bubbles;

    rst_n = 1'b0;
    lastExp = '0;
    v = randomIn(4'($urandom));
    freeze_i = 1'b0; flush_i = 1'b0; hazard_i = 1'b0; id_valid_i = 1'b1;
    id_instr_i = v.instr; id_cu_i = v.cu; id_pc_i = v.pc; id_val_rn_i = v.rn;
    id_val_rm_i = v.rm; id_dest_i = v.dest; status_nzcv_i = v.nzcv;

    // Reset held with random inputs across several edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkResetState("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table: hand-written outcomes for priority and condition corners
    vecs[0].in = randomIn(4'hE); vecs[0].in.cu = 9'h109; vecs[0].in.pc = 32'h10;
    vecs[0].expHold = 1'b0; vecs[0].expLoad = 1'b1;
    vecs[1].in = randomIn(4'hE); vecs[1].in.freeze = 1'b1; vecs[1].in.flush = 1'b1;
    vecs[1].expHold = 1'b1; vecs[1].expLoad = 1'b0;
    vecs[2].in = randomIn(4'hE); vecs[2].in.flush = 1'b1; vecs[2].in.hazard = 1'b1;
    vecs[2].expHold = 1'b0; vecs[2].expLoad = 1'b0;
    vecs[3].in = randomIn(4'h0); vecs[3].in.nzcv = 4'b0000;
    vecs[3].expHold = 1'b0; vecs[3].expLoad = 1'b0;
    vecs[4].in = randomIn(4'h0); vecs[4].in.nzcv = 4'b0100; vecs[4].in.cu = 9'h1FF;
    vecs[4].expHold = 1'b0; vecs[4].expLoad = 1'b1;
    vecs[5].in = randomIn(4'hE); vecs[5].in.valid = 1'b0;
    vecs[5].expHold = 1'b0; vecs[5].expLoad = 1'b0;
    vecs[6].in = randomIn(4'hF); vecs[6].in.cu = 9'h0C6;
    vecs[6].expHold = 1'b0; vecs[6].expLoad = 1'b1;
    vecs[7].in = randomIn(4'hE); vecs[7].in.freeze = 1'b1; vecs[7].in.hazard = 1'b1;
    vecs[7].expHold = 1'b1; vecs[7].expLoad = 1'b0;
    vecs[8].in = randomIn(4'hE); vecs[8].in.hazard = 1'b1;
    vecs[8].expHold = 1'b0; vecs[8].expLoad = 1'b0;
    vecs[9].in = randomIn(4'hE); vecs[9].in.freeze = 1'b1;
    vecs[9].expHold = 1'b1; vecs[9].expLoad = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].expHold) e = lastExp;
      else e = loadedExp(vecs[i].in, vecs[i].expLoad, lastExp);
      applyStimulus(vecs[i].in, e, $sformatf("vec%0d", i));
      if (i == 0) begin
        cmp("passthru wb_s_cmd", 32'({ex_wb_en_o, ex_s_o, ex_exe_cmd_o}), 32'b1_1_0010);
        cmp("passthru pc", ex_pc_o, 32'h10);
      end
    end

    // Full sweep of condition codes against every flag combination
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        v = randomIn(4'(c));
        v.nzcv = 4'(f);
        applyStimulus(v, modelNext(v, lastExp), $sformatf("sweep c%0h f%0h", c, f));
      end
    end

    // Hazard held for two cycles in the middle of a stream of always-execute instructions
    bubbles = 0;
    for (int i = 0; i < 6; i++) begin
      v = randomIn(4'hE);
      v.pc = 32'h100 + 32'(i * 4);
      v.hazard = (i == 2 || i == 3);
      applyStimulus(v, modelNext(v, lastExp), $sformatf("hazard%0d", i));
      if (!ex_valid_o) bubbles++;
    end
    cmp("hazard bubble count", 32'(bubbles), 32'd2);

    // Asynchronous reset between edges clears a live instruction without a clock
    v = randomIn(4'hE);
    applyStimulus(v, modelNext(v, lastExp), "preasync");
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    lastExp = '0;
    v = randomIn(4'hE);
    applyStimulus(v, modelNext(v, lastExp), "postasync");

    cmp("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
